// File: rtl/rv_r_issue.sv
// rv_r_issue: R-type decode/operand-issue stage feeding the ALU, with
// EX->ID forwarding, back-pressure, illegal-opcode flag and retire counter.
module rv_r_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [4:0]       alu_func3,
    output logic [6:0]       alu_func7,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    input  logic [XLEN-1:0]  alu_result,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data
);
    logic [XLEN-1:0] rf [NREGS];
    logic [4:0]      rd;
    logic            accept, retire, legal, wb;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] op1, op2;

    assign in_ready = !alu_valid || alu_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = alu_valid && alu_ready;
    assign wb       = retire && rd != 5'd0;
    assign legal    = in_instr[6:0] == 7'b0110011;
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];

    // x0 reads as zero and is never forwarded; otherwise the retiring result wins
    always_comb begin
        op1 = rs1 == 5'd0 ? '0 : (wb && rd == rs1) ? alu_result : rf[rs1];
        op2 = rs2 == 5'd0 ? '0 : (wb && rd == rs2) ? alu_result : rf[rs2];
    end

    assign dbg_data = dbg_addr == 5'd0 ? '0 : rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            rd        <= '0;
            alu_valid <= 1'b0;
            alu_func3 <= '0;
            alu_func7 <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            if (wb) rf[rd] <= alu_result;
            if (retire) retired <= retired + CNT_W'(1);
            illegal <= accept && !legal;
            if (accept && legal) begin
                alu_valid <= 1'b1;
                alu_func3 <= {2'b00, in_instr[14:12]};
                alu_func7 <= in_instr[31:25];
                alu_rs1   <= op1;
                alu_rs2   <= op2;
                rd        <= in_instr[11:7];
            end else if (retire) begin
                alu_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv_r_issue.sv
// tb_rv_r_issue: directed scenario tests for rv_r_issue with hand-computed expectations.
module tb_rv_r_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [4:0]  alu_func3;
    logic [6:0]  alu_func7;
    logic [31:0] alu_rs1, alu_rs2;
    logic [31:0] alu_result = '0;
    logic        illegal;
    logic [31:0] retired;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_ret = 0;

    localparam logic [31:0] ADD_X1_X0_X0 = 32'h000000B3;
    localparam logic [31:0] ADD_X2_X0_X0 = 32'h00000133;
    localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
    localparam logic [31:0] SUB_X4_X3_X1 = 32'h40118233;
    localparam logic [31:0] ADD_X8_X1_X4 = 32'h00408433;
    localparam logic [31:0] ADD_X5_X1_X2 = 32'h002082B3;
    localparam logic [31:0] ADDI_X5      = 32'h00108293;
    localparam logic [31:0] ADD_X0_X1_X2 = 32'h00208033;
    localparam logic [31:0] ADD_X7_X0_X0 = 32'h000003B3;

    rv_r_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_result(alu_result), .illegal(illegal),
        .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [31:0] ins, input logic r, input logic [31:0] res);
        in_valid = v; in_instr = ins; alu_ready = r; alu_result = res;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] ins, input logic [31:0] val);
        cyc(1'b1, ins, 1'b1, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, val);
        exp_ret = exp_ret + 1;
    endtask

    task automatic test_reset();
        tests++;
        if (alu_valid !== 1'b0 || alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0 || alu_func3 !== 5'h0 ||
            alu_func7 !== 7'h0 || illegal !== 1'b0 || retired !== 32'h0) begin
            fails++; $display("FAIL reset_state valid=%b rs1=%h rs2=%h f3=%h f7=%h ill=%b ret=%0d expected all zero",
                              alu_valid, alu_rs1, alu_rs2, alu_func3, alu_func7, illegal, retired);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        wr(ADD_X1_X0_X0, 32'd5);
        cyc(1'b1, ADD_X3_X1_X2, 1'b0, 32'h0);
        tests++;
        if (alu_valid !== 1'b1) begin fails++; $display("FAIL midreset_pre_valid got %b expected 1", alu_valid); end
        rst_n = 1'b0; #1;
        tests++;
        if (alu_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b expected 0", alu_valid); end
        @(posedge clk); #1; rst_n = 1'b1; in_valid = 1'b0; alu_ready = 1'b1;
        exp_ret = 0;
        @(posedge clk); #1;
        tests++;
        if (retired !== 32'h0 || alu_valid !== 1'b0) begin
            fails++; $display("FAIL midreset_after retired=%0d valid=%b expected 0/0", retired, alu_valid);
        end
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a); #1;
            tests++;
            if (dbg_data !== 32'h0) begin fails++; $display("FAIL reset_dbg x%0d got %h expected 0", a, dbg_data); end
        end
    endtask

    task automatic test_add();
        wr(ADD_X1_X0_X0, 32'd5);
        wr(ADD_X2_X0_X0, 32'd7);
        cyc(1'b1, ADD_X3_X1_X2, 1'b1, 32'h0);
        tests++;
        if (alu_valid !== 1'b1 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_func7 !== 7'h00 || alu_func3 !== 5'h0) begin
            fails++; $display("FAIL add_issue valid=%b rs1=%0d rs2=%0d f7=%h f3=%h expected 1/5/7/00/0",
                              alu_valid, alu_rs1, alu_rs2, alu_func7, alu_func3);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'd12);
        exp_ret = exp_ret + 1;
        dbg_addr = 5'd3; #1;
        tests++;
        if (dbg_data !== 32'd12) begin fails++; $display("FAIL add_wb x3 got %0d expected 12", dbg_data); end
        tests++;
        if (retired !== exp_ret) begin fails++; $display("FAIL add_retired got %0d expected %0d", retired, exp_ret); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, ADD_X3_X1_X2, 1'b1, 32'h0);
        cyc(1'b1, SUB_X4_X3_X1, 1'b1, 32'd12);
        tests++;
        if (alu_rs1 !== 32'd12 || alu_rs2 !== 32'd5 || alu_func7 !== 7'b0100000 || alu_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_fwd_rs1 rs1=%0d rs2=%0d f7=%b valid=%b expected 12/5/0100000/1",
                              alu_rs1, alu_rs2, alu_func7, alu_valid);
        end
        cyc(1'b1, ADD_X8_X1_X4, 1'b1, 32'd7);
        tests++;
        if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_func7 !== 7'h00) begin
            fails++; $display("FAIL b2b_fwd_rs2 rs1=%0d rs2=%0d f7=%h expected 5/7/00", alu_rs1, alu_rs2, alu_func7);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'd12);
        exp_ret = exp_ret + 3;
        dbg_addr = 5'd4; #1;
        tests++;
        if (dbg_data !== 32'd7) begin fails++; $display("FAIL b2b_wb x4 got %0d expected 7", dbg_data); end
        tests++;
        if (retired !== exp_ret || alu_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_retired got %0d valid=%b expected %0d/0", retired, alu_valid, exp_ret);
        end
    endtask

    task automatic test_stall();
        cyc(1'b1, ADD_X5_X1_X2, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (in_ready !== 1'b0 || alu_valid !== 1'b1 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 ||
                alu_func7 !== 7'h00 || alu_func3 !== 5'h0 || retired !== exp_ret) begin
                fails++; $display("FAIL stall_hold cycle %0d in_ready=%b valid=%b rs1=%0d rs2=%0d ret=%0d expected 0/1/5/7/%0d",
                                  k, in_ready, alu_valid, alu_rs1, alu_rs2, retired, exp_ret);
            end
            cyc(1'b1, SUB_X4_X3_X1, 1'b0, 32'd55);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'd99);
        exp_ret = exp_ret + 1;
        dbg_addr = 5'd5; #1;
        tests++;
        if (dbg_data !== 32'd99 || retired !== exp_ret || alu_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release x5=%0d ret=%0d valid=%b expected 99/%0d/0", dbg_data, retired, alu_valid, exp_ret);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'd11);
        tests++;
        if (retired !== exp_ret || dbg_data !== 32'd99) begin
            fails++; $display("FAIL stall_single_wb ret=%0d x5=%0d expected %0d/99", retired, dbg_data, exp_ret);
        end
    endtask

    task automatic test_illegal();
        cyc(1'b1, ADDI_X5, 1'b1, 32'h0);
        tests++;
        if (illegal !== 1'b1 || alu_valid !== 1'b0) begin
            fails++; $display("FAIL illegal_pulse ill=%b valid=%b expected 1/0", illegal, alu_valid);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h1234);
        dbg_addr = 5'd5; #1;
        tests++;
        if (illegal !== 1'b0 || retired !== exp_ret || dbg_data !== 32'd99) begin
            fails++; $display("FAIL illegal_after ill=%b ret=%0d x5=%0d expected 0/%0d/99", illegal, retired, dbg_data, exp_ret);
        end
    endtask

    task automatic test_x0();
        cyc(1'b1, ADD_X0_X1_X2, 1'b1, 32'h0);
        cyc(1'b1, ADD_X7_X0_X0, 1'b1, 32'hDEADBEEF);
        tests++;
        if (alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0 || alu_valid !== 1'b1) begin
            fails++; $display("FAIL x0_operand rs1=%h rs2=%h valid=%b expected 0/0/1", alu_rs1, alu_rs2, alu_valid);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'd3);
        exp_ret = exp_ret + 2;
        dbg_addr = 5'd0; #1;
        tests++;
        if (dbg_data !== 32'h0 || retired !== exp_ret) begin
            fails++; $display("FAIL x0_wb x0=%h ret=%0d expected 0/%0d", dbg_data, retired, exp_ret);
        end
        dbg_addr = 5'd7; #1;
        tests++;
        if (dbg_data !== 32'd3) begin fails++; $display("FAIL x0_reader_wb x7 got %0d expected 3", dbg_data); end
    endtask

    initial begin
        #2;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_x0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv_r_issue.md
Name: rv_r_issue

Overview:
- Decode/operand-issue stage directly upstream of the R-type ALU.
- Accepts 32-bit RV32I R-type instructions over a valid/ready handshake and reads rs1/rs2 from an internal 32x32 register file.
- Registers func3/func7/operands toward the ALU, then writes the ALU result back to rd.
- Provides EX->ID forwarding, back-pressure, illegal-opcode flagging and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, architectural registers; x0 is hardwired to zero
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction present on in_instr
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  32  instruction word
- alu_valid  output  1  EX register holds a valid op
- alu_ready  input  1  ALU result consumed this cycle (downstream may stall)
- alu_func3  output  5  {2'b00, instr[14:12]}
- alu_func7  output  7  instr[31:25]
- alu_rs1  output  XLEN  operand 1
- alu_rs2  output  XLEN  operand 2
- alu_result  input  XLEN  combinational ALU result for current EX op
- illegal  output  1  one-cycle pulse: accepted instr had opcode != 7'b0110011
- retired  output  CNT_W  count of R-type instructions written back
- dbg_addr  input  5  debug read address
- dbg_data  output  XLEN  regfile[dbg_addr], combinational; 0 when dbg_addr==0

Behaviour:
- Reset (async, rst_n low):
  - alu_valid=0, alu_func3=0, alu_func7=0, alu_rs1=0, alu_rs2=0, illegal=0, retired=0.
  - All registers cleared to 0; in_ready=1 once rst_n deasserts.
  - Reset mid-operation discards the in-flight EX op with no writeback.
- Handshakes:
  - in_ready = !alu_valid || alu_ready (combinational).
  - Accept = in_valid && in_ready.
  - Retire = alu_valid && alu_ready.
- EX register update on accept of a legal R-type instruction (opcode 0110011):
  - Next cycle: alu_valid=1.
  - func3/func7 taken from the instruction.
  - rd latched internally.
  - alu_rs1/alu_rs2 set to the forwarded operand values below.
- Accept of an illegal instruction:
  - illegal=1 for exactly the next cycle; the instruction is dropped.
  - alu_valid=0 next cycle, unless a legal op is accepted.
- Retire with no accept: alu_valid=0 next cycle.
- Stall (alu_valid && !alu_ready):
  - All alu_* outputs hold stable.
  - in_ready=0; no writeback.
- Latency: accept in cycle N -> alu_* valid in cycle N+1. With alu_ready=1, writeback and retired increment at the end of cycle N+1. Throughput is 1 instr/cycle.
- Writeback: on retire with rd!=0, regfile[rd] <= alu_result. With rd==0, no write occurs, but retired still increments.
- Forwarding: when accepting in the same cycle as a retire whose rd!=0, each source register equal to the retiring rd takes alu_result instead of the regfile value.
- Source reg 0: operand is always 0, never forwarded.
- retired: increments by 1 per retire and wraps modulo 2^CNT_W.
- dbg_data: shows the regfile state and reflects a writeback from the cycle after the write.
- Simultaneous accept + retire: both take effect in the same edge; the new op replaces the EX register.

Test Plan:
- Reset with rst_n low mid-stream, in EX: alu_valid=1 -> alu_valid=0, retired=0, dbg_data=0 for every address after release.
- Write value 5 to x1 and 7 to x2, then issue ADD x3,x1,x2 (0x002081B3) with alu_result=12 -> next cycle alu_rs1=5, alu_rs2=7, func7=0, func3=0; dbg x3=12; retired +1.
- Back-to-back ADD x3,x1,x2 then SUB x4,x3,x1 (0x40118233), alu_result=12 then 7:
  - Second op sees alu_rs1=12 (forwarded) and alu_func7=0100000.
  - dbg x4=7.
- alu_ready held low 3 cycles with in_valid high -> in_ready=0 and alu_* stable throughout; exactly one writeback after alu_ready rises.
- Issue opcode 0010011 (ADDI) -> illegal pulse of one cycle, alu_valid=0, no regfile change, retired unchanged.
- ADD x0,x1,x2 retires with alu_result=0xDEADBEEF -> dbg x0=0, retired +1. A following op reading x0 gets operand 0.
